neuron_act_fork: RTL and testbench

- Next-generation activation stage for the fixed-point MLP datapath. It sits between the accumulator and the state memories.
- Takes NC accumulated sums per beat and applies a clipped ReLU or leaky ReLU (hidden layer) or identity (output layer).
- Forks each result to two consumers with independent handshakes: State0 receives the activation; State1 receives per-channel derivative flags, in training mode only.
- Keeps a saturating count of clipped channels for overflow monitoring.

---
 rtl/neuron_act_fork.sv | 113 +++++++++++
 tb/tb_neuron_act_fork.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_act_fork.sv
// Activation stage: clipped/leaky ReLU or identity per channel, forked to two
// consumers with independent handshakes, plus a saturating clip counter.
module neuron_act_fork #(
  parameter  int HIDDEN     = 1,
  parameter  int NP         = 4,
  parameter  int NC         = 4,
  parameter  int WF         = 4,
  parameter  int LEAK_SHIFT = 0,
  parameter  int CW         = 16,
  localparam int WV         = $clog2(NP) + WF,
  localparam int WN         = (HIDDEN != 0) ? WF : WV
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iMode,
  input  logic             iValid_AS_Accum0,
  output logic             oReady_AS_Accum0,
  input  logic [NC*WV-1:0] iData_AS_Accum0,
  output logic             oValid_BM_State0,
  input  logic             iReady_BM_State0,
  output logic [NC*WN-1:0] oData_BM_State0,
  output logic             oValid_BM_State1,
  input  logic             iReady_BM_State1,
  output logic [NC-1:0]    oData_BM_State1,
  input  logic             iClr,
  output logic [CW-1:0]    oClipCnt
);

  localparam logic signed [WV-1:0] maxV = WV'(2**(WF-1) - 1);
  localparam logic signed [WV-1:0] minV = WV'(-(2**(WF-1)));
  localparam int CNTW = $clog2(NC + 1);

  logic signed [WV-1:0] v;
  logic signed [WV-1:0] t;
  logic [NC*WN-1:0]     yAll;
  logic [NC-1:0]        dAll;
  logic [CNTW-1:0]      clips;

  logic [NC*WN-1:0]     rData0;
  logic [NC-1:0]        rData1;
  logic                 rP0;
  logic                 rP1;
  logic                 acc;
  logic [CW:0]          sum;

  always_comb begin
    v     = '0;
    t     = '0;
    yAll  = '0;
    dAll  = '0;
    clips = '0;
    for (int unsigned c = 0; c < NC; c++) begin
      v = $signed(iData_AS_Accum0[c*WV +: WV]);
      t = v >>> LEAK_SHIFT;
      if (HIDDEN == 0) begin
        yAll[c*WN +: WN] = WN'(v);
        dAll[c]          = 1'b1;
      end else if (v > maxV) begin
        yAll[c*WN +: WN] = WN'(maxV);
        clips            = clips + CNTW'(1);
      end else if (v >= 0) begin
        yAll[c*WN +: WN] = WN'(v);
        dAll[c]          = 1'b1;
      end else if (LEAK_SHIFT == 0) begin
        yAll[c*WN +: WN] = '0;
      end else if (t < minV) begin
        yAll[c*WN +: WN] = WN'(minV);
        clips            = clips + CNTW'(1);
      end else begin
        yAll[c*WN +: WN] = WN'(t);
      end
    end
  end

  // Input is held until every pending copy has been taken by its consumer.
  assign oReady_AS_Accum0 = (!rP0 | iReady_BM_State0) & (!rP1 | iReady_BM_State1);
  assign acc              = iValid_AS_Accum0 & oReady_AS_Accum0;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rData0 <= '0;
      rData1 <= '0;
      rP0    <= 1'b0;
      rP1    <= 1'b0;
    end else if (acc) begin
      rData0 <= yAll;
      rData1 <= dAll;
      rP0    <= 1'b1;
      rP1    <= iMode;
    end else begin
      if (iReady_BM_State0) rP0 <= 1'b0;
      if (iReady_BM_State1) rP1 <= 1'b0;
    end
  end

  assign sum = {1'b0, oClipCnt} + (CW+1)'(clips);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oClipCnt <= '0;
    end else if (iClr) begin
      oClipCnt <= '0;
    end else if (acc) begin
      oClipCnt <= sum[CW] ? '1 : sum[CW-1:0];
    end
  end

  assign oValid_BM_State0 = rP0;
  assign oValid_BM_State1 = rP1;
  assign oData_BM_State0  = rData0;
  assign oData_BM_State1  = rData1;

endmodule

// File: tb/tb_neuron_act_fork.sv
// Bench for neuron_act_fork: four parameterisations driven in lockstep and
// compared every cycle against a behavioural model of the activation and fork.
module tb_neuron_act_fork;

  logic        iCLK = 1'b0;
  logic        iRST, iMode, iValid, iReady0, iReady1, iClr;
  logic [23:0] iData;

  logic        rdyW[4], v0W[4], v1W[4];
  logic [3:0]  d1W[4];
  logic [15:0] cntW[4];
  logic signed [31:0] yW[4][4];

  logic [15:0] dat0A, dat0B, dat0D;
  logic [23:0] dat0C;
  logic [15:0] cntA, cntB, cntC;
  logic [3:0]  cntD;

  int checks = 0;
  int errors = 0;

  // model state
  logic mp0, mp1;
  int   md0[4][4];
  logic [3:0] md1[4];
  int   mcnt[4];
  int   vIn[4];
  int   hidK[4]  = '{1, 1, 0, 1};
  int   leakK[4] = '{0, 1, 0, 0};
  int   maxK[4]  = '{65535, 65535, 65535, 15};

  always #5 iCLK = ~iCLK;

  neuron_act_fork #(.HIDDEN(1), .NP(4), .NC(4), .WF(4), .LEAK_SHIFT(0), .CW(16)) dutA (
    .iCLK(iCLK), .iRST(iRST), .iMode(iMode), .iValid_AS_Accum0(iValid),
    .oReady_AS_Accum0(rdyW[0]), .iData_AS_Accum0(iData),
    .oValid_BM_State0(v0W[0]), .iReady_BM_State0(iReady0), .oData_BM_State0(dat0A),
    .oValid_BM_State1(v1W[0]), .iReady_BM_State1(iReady1), .oData_BM_State1(d1W[0]),
    .iClr(iClr), .oClipCnt(cntA));

  neuron_act_fork #(.HIDDEN(1), .NP(4), .NC(4), .WF(4), .LEAK_SHIFT(1), .CW(16)) dutB (
    .iCLK(iCLK), .iRST(iRST), .iMode(iMode), .iValid_AS_Accum0(iValid),
    .oReady_AS_Accum0(rdyW[1]), .iData_AS_Accum0(iData),
    .oValid_BM_State0(v0W[1]), .iReady_BM_State0(iReady0), .oData_BM_State0(dat0B),
    .oValid_BM_State1(v1W[1]), .iReady_BM_State1(iReady1), .oData_BM_State1(d1W[1]),
    .iClr(iClr), .oClipCnt(cntB));

  neuron_act_fork #(.HIDDEN(0), .NP(4), .NC(4), .WF(4), .LEAK_SHIFT(0), .CW(16)) dutC (
    .iCLK(iCLK), .iRST(iRST), .iMode(iMode), .iValid_AS_Accum0(iValid),
    .oReady_AS_Accum0(rdyW[2]), .iData_AS_Accum0(iData),
    .oValid_BM_State0(v0W[2]), .iReady_BM_State0(iReady0), .oData_BM_State0(dat0C),
    .oValid_BM_State1(v1W[2]), .iReady_BM_State1(iReady1), .oData_BM_State1(d1W[2]),
    .iClr(iClr), .oClipCnt(cntC));

  neuron_act_fork #(.HIDDEN(1), .NP(4), .NC(4), .WF(4), .LEAK_SHIFT(0), .CW(4)) dutD (
    .iCLK(iCLK), .iRST(iRST), .iMode(iMode), .iValid_AS_Accum0(iValid),
    .oReady_AS_Accum0(rdyW[3]), .iData_AS_Accum0(iData),
    .oValid_BM_State0(v0W[3]), .iReady_BM_State0(iReady0), .oData_BM_State0(dat0D),
    .oValid_BM_State1(v1W[3]), .iReady_BM_State1(iReady1), .oData_BM_State1(d1W[3]),
    .iClr(iClr), .oClipCnt(cntD));

  always_comb begin
    cntW[0] = cntA;
    cntW[1] = cntB;
    cntW[2] = cntC;
    cntW[3] = {12'b0, cntD};
    for (int c = 0; c < 4; c++) begin
      yW[0][c] = 32'($signed(dat0A[c*4 +: 4]));
      yW[1][c] = 32'($signed(dat0B[c*4 +: 4]));
      yW[2][c] = 32'($signed(dat0C[c*6 +: 6]));
      yW[3][c] = 32'($signed(dat0D[c*4 +: 4]));
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Activation from the rules, using floor division for the leaky slope.
  function automatic void act(input int v, input int hid, input int lk,
                              output int y, output bit d, output bit cl);
    int t, p;
    y = v; d = 1'b1; cl = 1'b0;
    if (hid != 0) begin
      if (v > 7) begin
        y = 7; d = 1'b0; cl = 1'b1;
      end else if (v < 0) begin
        d = 1'b0;
        if (lk == 0) y = 0;
        else begin
          p = 2 ** lk;
          t = (v - (p - 1)) / p;
          if (t < -8) begin y = -8; cl = 1'b1; end
          else y = t;
        end
      end
    end
  endfunction

  task automatic modelReset();
    mp0 = 1'b0; mp1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      md1[k] = '0; mcnt[k] = 0;
      for (int c = 0; c < 4; c++) md0[k][c] = 0;
    end
  endtask

  task automatic setData(input int a, input int b, input int c, input int d);
    vIn[0] = a; vIn[1] = b; vIn[2] = c; vIn[3] = d;
    for (int i = 0; i < 4; i++) iData[i*6 +: 6] = 6'(vIn[i]);
  endtask

  task automatic randData();
    setData(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
            int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
  endtask

  task automatic cycle();
    bit acc, expRdy, d, cl;
    int y, nClip;
    @(negedge iCLK);
    expRdy = (!mp0 || iReady0) && (!mp1 || iReady1);
    for (int k = 0; k < 4; k++) begin
      checkVal($sformatf("dut%0d.ready", k), 32'(rdyW[k]), 32'(expRdy));
      checkVal($sformatf("dut%0d.valid0", k), 32'(v0W[k]), 32'(mp0));
      checkVal($sformatf("dut%0d.valid1", k), 32'(v1W[k]), 32'(mp1));
      checkVal($sformatf("dut%0d.deriv", k), 32'(d1W[k]), 32'(md1[k]));
      checkVal($sformatf("dut%0d.clipcnt", k), 32'(cntW[k]), mcnt[k]);
      for (int c = 0; c < 4; c++)
        checkVal($sformatf("dut%0d.y%0d", k, c), yW[k][c], md0[k][c]);
    end
    acc = iRST && iValid && expRdy;
    @(posedge iCLK);
    if (!iRST) modelReset();
    else begin
      for (int k = 0; k < 4; k++) begin
        nClip = 0;
        if (acc) begin
          for (int c = 0; c < 4; c++) begin
            act(vIn[c], hidK[k], leakK[k], y, d, cl);
            md0[k][c] = y; md1[k][c] = d; nClip += int'(cl);
          end
        end
        if (iClr) mcnt[k] = 0;
        else if (acc) mcnt[k] = (mcnt[k] + nClip > maxK[k]) ? maxK[k] : mcnt[k] + nClip;
      end
      if (acc) begin
        mp0 = 1'b1; mp1 = iMode;
      end else begin
        if (iReady0) mp0 = 1'b0;
        if (iReady1) mp1 = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    iRST = 1'b0; iMode = 1'b0; iValid = 1'b0; iReady0 = 1'b1; iReady1 = 1'b1; iClr = 1'b0;
    setData(0, 0, 0, 0);
    modelReset();
    cycle();
    iRST = 1'b1;
    cycle();

    // inference beat
    setData(-3, 5, 9, 0); iValid = 1'b1; iMode = 1'b0;
    cycle();
    iValid = 1'b0;
    checkVal("inf.y0", yW[0][0], 0);
    checkVal("inf.y1", yW[0][1], 5);
    checkVal("inf.y2", yW[0][2], 7);
    checkVal("inf.y3", yW[0][3], 0);
    checkVal("inf.valid1", 32'(v1W[0]), 0);
    checkVal("inf.clipcnt", 32'(cntW[0]), 1);
    cycle();

    // training beat
    iValid = 1'b1; iMode = 1'b1;
    cycle();
    iValid = 1'b0;
    checkVal("trn.valid0", 32'(v0W[0]), 1);
    checkVal("trn.valid1", 32'(v1W[0]), 1);
    checkVal("trn.deriv", 32'(d1W[0]), 32'(4'b1010));
    cycle();
    checkVal("trn.valid0.clr", 32'(v0W[0]), 0);
    checkVal("trn.valid1.clr", 32'(v1W[0]), 0);

    // fork skew: State1 stalls for 3 cycles
    randData(); iValid = 1'b1; iMode = 1'b1;
    cycle();
    randData(); iReady1 = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    checkVal("skew.valid0", 32'(v0W[0]), 0);
    checkVal("skew.valid1", 32'(v1W[0]), 1);
    checkVal("skew.ready", 32'(rdyW[0]), 0);
    iReady1 = 1'b1;
    cycle();
    iValid = 1'b0;
    cycle();

    // streaming
    for (int i = 0; i < 8; i++) begin
      randData(); iValid = 1'b1; iMode = 1'b1;
      cycle();
    end
    iValid = 1'b0;
    cycle();

    // leaky slope and output-layer identity
    setData(-6, -32, -20, 3); iValid = 1'b1;
    cycle();
    iValid = 1'b0;
    checkVal("leak.y0", yW[1][0], -3);
    checkVal("leak.y1", yW[1][1], -8);
    checkVal("ident.y2", yW[2][2], -20);
    checkVal("ident.deriv2", 32'(d1W[2][2]), 1);
    cycle();

    // counter saturation at 4 bits
    iClr = 1'b1;
    cycle();
    iClr = 1'b0;
    setData(20, 20, 20, 20);
    for (int i = 0; i < 5; i++) begin
      iValid = 1'b1;
      cycle();
    end
    iValid = 1'b0;
    cycle();
    checkVal("sat.clipcnt", 32'(cntW[3]), 15);

    // clear wins over a clipping beat
    iClr = 1'b1; iValid = 1'b1;
    cycle();
    iClr = 1'b0; iValid = 1'b0;
    checkVal("clr.clipcnt3", 32'(cntW[3]), 0);
    checkVal("clr.clipcnt0", 32'(cntW[0]), 0);
    cycle();

    // reset with State1 pending
    randData(); iValid = 1'b1; iMode = 1'b1; iReady1 = 1'b0;
    cycle();
    iValid = 1'b0;
    #2 iRST = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkVal($sformatf("rst.dut%0d.valid0", k), 32'(v0W[k]), 0);
      checkVal($sformatf("rst.dut%0d.valid1", k), 32'(v1W[k]), 0);
    end
    modelReset();
    iValid = 1'b1;
    cycle();
    iRST = 1'b1; iValid = 1'b0; iReady1 = 1'b1;
    cycle();
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      randData();
      iValid  = ($urandom_range(0, 3) != 0);
      iMode   = $urandom_range(0, 1) != 0;
      iReady0 = ($urandom_range(0, 3) != 0);
      iReady1 = ($urandom_range(0, 3) != 0);
      iClr    = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
